// File: rtl/lb_seq_master_if.sv
// Bundle of command, block-read and local-bus signals for lb_seq_master.
// Command handshake: a word transfers on a rising edge where cmd_valid && cmd_ready; the producer holds cmd_* stable until then.
interface lb_seq_master_if #(
  parameter int AW    = 17,
  parameter int DW    = 32,
  parameter int LEN_W = 11
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [DW-1:0]    cmd_data;
  logic             rd_start;
  logic [AW-1:0]    rd_base;
  logic [LEN_W-1:0] rd_len;
  logic             busy;
  logic [AW-1:0]    lb_addr;
  logic [DW-1:0]    lb_data;
  logic             lb_write;
  logic             lb_read;
  logic [DW-1:0]    lb_out;
  logic             rd_valid;
  logic [DW-1:0]    rd_data;
  logic [LEN_W-1:0] rd_index;
  logic             rd_done;

  modport master (
    input  cmd_valid, cmd_addr, cmd_data, rd_start, rd_base, rd_len, lb_out,
    output cmd_ready, busy, lb_addr, lb_data, lb_write, lb_read,
           rd_valid, rd_data, rd_index, rd_done
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_data, rd_start, rd_base, rd_len, lb_out,
    input  cmd_ready, busy, lb_addr, lb_data, lb_write, lb_read,
           rd_valid, rd_data, rd_index, rd_done
  );
endinterface

// File: rtl/lb_seq_master.sv
// Local-bus master: replays spaced register writes and stall commands, then
// runs block reads and re-times lb_out through the fixed read pipeline.
module lb_seq_master #(
  parameter int            AW         = 17,
  parameter int            DW         = 32,
  parameter logic [AW-1:0] STALL_ADDR = AW'(555),
  parameter int            WRITE_GAP  = 3,
  parameter int            READ_PIPE  = 2,
  parameter int            LEN_W      = 11
) (
  input  logic lb_clk,
  input  logic lb_rst,
  lb_seq_master_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_STALL, S_READ, S_DRAIN} state_t;

  // GAP counts down from here so that GAP lasts WRITE_GAP-1 cycles.
  localparam logic [DW-1:0] GAP_INIT = (WRITE_GAP > 1) ? DW'(WRITE_GAP - 2) : '0;

  state_t                          state_q, state_d;
  logic [DW-1:0]                   cnt_q, cnt_d;
  logic [LEN_W-1:0]                len_q, len_d;
  logic [LEN_W-1:0]                idx_q, idx_d;
  logic [AW-1:0]                   lb_addr_q, lb_addr_d;
  logic [DW-1:0]                   lb_data_q, lb_data_d;
  logic                            lb_write_q, lb_write_d;
  logic                            lb_read_q, lb_read_d;
  logic [READ_PIPE-1:0]            pv_q, pv_d;
  logic [READ_PIPE-1:0][LEN_W-1:0] pi_q, pi_d;
  logic                            rd_valid_q, rd_valid_d;
  logic [DW-1:0]                   rd_data_q, rd_data_d;
  logic [LEN_W-1:0]                rd_index_q, rd_index_d;
  logic                            rd_done_q, rd_done_d;
  logic                            busy_q, busy_d;
  logic [LEN_W:0]                  idx_nxt;

  assign bus.cmd_ready = (state_q == S_IDLE) && !bus.rd_start && !lb_rst;
  assign bus.busy      = busy_q;
  assign bus.lb_addr   = lb_addr_q;
  assign bus.lb_data   = lb_data_q;
  assign bus.lb_write  = lb_write_q;
  assign bus.lb_read   = lb_read_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_index  = rd_index_q;
  assign bus.rd_done   = rd_done_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    lb_addr_d  = lb_addr_q;
    lb_data_d  = '0;
    lb_write_d = 1'b0;
    lb_read_d  = 1'b0;
    rd_done_d  = 1'b0;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    idx_nxt    = {1'b0, idx_q} + 1'b1;

    // Return pipe: stage 0 tags the read currently on the bus.
    pv_d[0] = lb_read_q;
    pi_d[0] = idx_q;
    for (int k = 1; k < READ_PIPE; k++) begin
      pv_d[k] = pv_q[k-1];
      pi_d[k] = pi_q[k-1];
    end
    rd_valid_d = pv_q[READ_PIPE-1];
    if (pv_q[READ_PIPE-1]) begin
      rd_data_d  = bus.lb_out;
      rd_index_d = pi_q[READ_PIPE-1];
    end

    case (state_q)
      S_IDLE: begin
        if (bus.rd_start) begin
          len_d = bus.rd_len;
          idx_d = '0;
          if (bus.rd_len != '0) begin
            state_d   = S_READ;
            lb_read_d = 1'b1;
            lb_addr_d = bus.rd_base;
          end else begin
            state_d = S_DRAIN;
          end
        end else if (bus.cmd_valid) begin
          if (bus.cmd_addr == STALL_ADDR) begin
            state_d = S_STALL;
            cnt_d   = bus.cmd_data;
          end else begin
            state_d    = S_WRITE;
            lb_write_d = 1'b1;
            lb_addr_d  = bus.cmd_addr;
            lb_data_d  = bus.cmd_data;
          end
        end
      end
      S_WRITE: begin
        if (WRITE_GAP > 1) begin
          state_d = S_GAP;
          cnt_d   = GAP_INIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GAP, S_STALL: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_READ: begin
        if (idx_nxt < {1'b0, len_q}) begin
          lb_read_d = 1'b1;
          lb_addr_d = lb_addr_q + AW'(1);
          idx_d     = idx_nxt[LEN_W-1:0];
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Fires the cycle the last word sits in the output register.
        if (pv_q == '0) begin
          rd_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge lb_clk or posedge lb_rst) begin
    if (lb_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      lb_addr_q  <= '0;
      lb_data_q  <= '0;
      lb_write_q <= 1'b0;
      lb_read_q  <= 1'b0;
      pv_q       <= '0;
      pi_q       <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      rd_done_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      lb_addr_q  <= lb_addr_d;
      lb_data_q  <= lb_data_d;
      lb_write_q <= lb_write_d;
      lb_read_q  <= lb_read_d;
      pv_q       <= pv_d;
      pi_q       <= pi_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      rd_done_q  <= rd_done_d;
      busy_q     <= busy_d;
    end
  end

endmodule
